// File: rtl/lc3_pkg.sv
// Shared widths and loader FSM state encoding.
package lc3_pkg;

    localparam int unsigned LC3_ADDR_W = 16;
    localparam int unsigned LC3_DATA_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SETPC = 2'd2;
    localparam state_t ST_RUN   = 2'd3;

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: load request, instruction stream, memory write port and CPU control.
interface prog_loader_if
#(
    parameter int unsigned ADDR_W = lc3_pkg::LC3_ADDR_W,
    parameter int unsigned DATA_W = lc3_pkg::LC3_DATA_W
);
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pc_ld;
    logic [ADDR_W-1:0] pc_val;
    logic              cpu_run;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] word_count;

    modport slave (
        input  load_start, load_base, in_valid, in_data, in_last, cpu_halt,
        output in_ready, mem_we, mem_addr, mem_wdata, pc_ld, pc_val,
               cpu_run, busy, done, err, word_count
    );

    modport master (
        output load_start, load_base, in_valid, in_data, in_last, cpu_halt,
        input  in_ready, mem_we, mem_addr, mem_wdata, pc_ld, pc_val,
               cpu_run, busy, done, err, word_count
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a program into memory, loads the PC with the base address and
// runs the CPU until HALT.
module prog_loader
    import lc3_pkg::*;
#(
    parameter int unsigned ADDR_W = LC3_ADDR_W,
    parameter int unsigned DATA_W = LC3_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_word_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_in_ready;
    logic              r_pc_ld;
    logic              r_cpu_run;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_start;
    logic              w_accept;
    logic              w_halt;
    logic              w_addr_top;

    assign w_start    = (r_state == ST_IDLE) && bus.load_start;
    assign w_accept   = (r_state == ST_LOAD) && bus.in_valid;
    assign w_halt     = (r_state == ST_RUN)  && bus.cpu_halt;
    assign w_addr_top = &r_addr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.load_start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (bus.in_valid) begin
                    if (bus.in_last)      w_state_nxt = ST_SETPC;
                    else if (w_addr_top)  w_state_nxt = ST_IDLE;
                end
            end
            ST_SETPC: w_state_nxt = ST_RUN;
            ST_RUN:   if (bus.cpu_halt) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_pc_ld    <= 1'b0;
            r_cpu_run  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == ST_LOAD);
            r_pc_ld    <= (w_state_nxt == ST_SETPC);
            r_cpu_run  <= (w_state_nxt == ST_RUN);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_halt;
        end
    end

    // Address/word counters and the delayed memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_base       <= '0;
            r_word_count <= '0;
            r_err        <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= w_accept;
            if (w_start) begin
                r_addr       <= bus.load_base;
                r_base       <= bus.load_base;
                r_word_count <= '0;
                r_err        <= 1'b0;
            end
            if (w_accept) begin
                r_mem_addr   <= r_addr;
                r_mem_wdata  <= bus.in_data;
                r_addr       <= r_addr + ADDR_W'(1);
                r_word_count <= r_word_count + ADDR_W'(1);
                if (!bus.in_last && w_addr_top) r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.pc_ld      = r_pc_ld;
    assign bus.pc_val     = r_base;
    assign bus.cpu_run    = r_cpu_run;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; memory writes are checked against a queue
// of expected {addr, data} pairs filled as words are offered.
module tb_prog_loader;
    import lc3_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    wr_t         exp_q[$];
    wr_t         got;
    logic [15:0] exp_addr;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    prog_loader_if bus ();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample; any write strobe must match the queue head.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.mem_we === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_mem_we: observed addr %0h expected no write", bus.mem_addr);
            end
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                chk("mem_addr",  32'(bus.mem_addr),  32'(got.addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(got.data));
            end
        end
    endtask

    task automatic drive_word(input logic [15:0] data, input logic last, input logic exp_acc);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        chk("in_ready_offer", 32'(bus.in_ready), 32'(exp_acc));
        if (exp_acc) begin
            exp_q.push_back('{addr: exp_addr, data: data});
            exp_addr = exp_addr + 16'd1;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] base);
        bus.load_base  = base;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        exp_addr = base;
        chk("start_busy",     32'(bus.busy),       32'd1);
        chk("start_in_ready", 32'(bus.in_ready),   32'd1);
        chk("start_wcount",   32'(bus.word_count), 32'd0);
        chk("start_err",      32'(bus.err),        32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.cpu_halt   = 1'b0;
        exp_addr       = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy",     32'(bus.busy),       32'd0);
        chk("rst_in_ready", 32'(bus.in_ready),   32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),     32'd0);
        chk("rst_cpu_run",  32'(bus.cpu_run),    32'd0);
        chk("rst_done",     32'(bus.done),       32'd0);
        chk("rst_err",      32'(bus.err),        32'd0);
        chk("rst_wcount",   32'(bus.word_count), 32'd0);
        chk("rst_pc_val",   32'(bus.pc_val),     32'd0);

        // Three-word program at 0x3000, back to back.
        start_load(16'h3000);
        drive_word(16'h1021, 1'b0, 1'b1);
        drive_word(16'h1262, 1'b0, 1'b1);
        drive_word(16'hF025, 1'b1, 1'b1);
        chk("setpc_pc_ld",   32'(bus.pc_ld),      32'd1);
        chk("setpc_pc_val",  32'(bus.pc_val),     32'h3000);
        chk("setpc_cpu_run", 32'(bus.cpu_run),    32'd0);
        chk("setpc_ready",   32'(bus.in_ready),   32'd0);
        chk("setpc_wcount",  32'(bus.word_count), 32'd3);
        chk("writes_drained", 32'(exp_q.size()),  32'd0);
        tick();
        chk("run_cpu_run", 32'(bus.cpu_run), 32'd1);
        chk("run_pc_ld",   32'(bus.pc_ld),   32'd0);

        // load_start in RUN is ignored.
        bus.load_base  = 16'h1234;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("run_ls_cpu_run", 32'(bus.cpu_run),    32'd1);
        chk("run_ls_pc_val",  32'(bus.pc_val),     32'h3000);
        chk("run_ls_wcount",  32'(bus.word_count), 32'd3);

        // HALT returns to IDLE with a one-cycle done pulse.
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
        chk("halt_done",    32'(bus.done),    32'd1);
        chk("halt_cpu_run", 32'(bus.cpu_run), 32'd0);
        chk("halt_busy",    32'(bus.busy),    32'd0);
        tick();
        chk("done_pulse_end", 32'(bus.done),       32'd0);
        chk("idle_wcount",    32'(bus.word_count), 32'd3);
        chk("idle_pc_val",    32'(bus.pc_val),     32'h3000);
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
        chk("idle_halt_done", 32'(bus.done), 32'd0);

        // Address overflow without in_last.
        start_load(16'hFFFE);
        drive_word(16'hAAAA, 1'b0, 1'b1);
        drive_word(16'hBBBB, 1'b0, 1'b1);
        chk("ovf_err",  32'(bus.err),  32'd1);
        chk("ovf_busy", 32'(bus.busy), 32'd0);
        drive_word(16'hCCCC, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ovf_pc_ld",   32'(bus.pc_ld),   32'd0);
            chk("ovf_cpu_run", 32'(bus.cpu_run), 32'd0);
            chk("ovf_done",    32'(bus.done),    32'd0);
            tick();
        end
        chk("ovf_err_hold", 32'(bus.err),        32'd1);
        chk("ovf_wcount",   32'(bus.word_count), 32'd2);
        chk("ovf_drained",  32'(exp_q.size()),   32'd0);

        // Gap in in_valid; load_start and cpu_halt during LOAD are ignored.
        start_load(16'h0100);
        drive_word(16'h5A5A, 1'b0, 1'b1);
        bus.in_data    = 16'hDEAD;
        bus.load_base  = 16'h5555;
        bus.load_start = 1'b1;
        bus.cpu_halt   = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.cpu_halt   = 1'b0;
        chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
        chk("gap_done",     32'(bus.done),     32'd0);
        drive_word(16'hA5A5, 1'b1, 1'b1);
        chk("gap_pc_val", 32'(bus.pc_val),     32'h0100);
        chk("gap_wcount", 32'(bus.word_count), 32'd2);
        tick();
        chk("gap_cpu_run", 32'(bus.cpu_run), 32'd1);
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
        chk("gap_halt_done", 32'(bus.done), 32'd1);

        // Reset after two of four words; the word offered in the reset cycle is dropped.
        start_load(16'h4000);
        drive_word(16'h0001, 1'b0, 1'b1);
        drive_word(16'h0002, 1'b0, 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0003;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", 32'(bus.in_ready),   32'd0);
        chk("mrst_mem_we",   32'(bus.mem_we),     32'd0);
        chk("mrst_pc_ld",    32'(bus.pc_ld),      32'd0);
        chk("mrst_cpu_run",  32'(bus.cpu_run),    32'd0);
        chk("mrst_busy",     32'(bus.busy),       32'd0);
        chk("mrst_done",     32'(bus.done),       32'd0);
        chk("mrst_err",      32'(bus.err),        32'd0);
        chk("mrst_wcount",   32'(bus.word_count), 32'd0);
        chk("mrst_pc_val",   32'(bus.pc_val),     32'd0);
        bus.in_data = 16'h0004;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("mrst_idle_busy", 32'(bus.busy),     32'd0);
        chk("final_drained",  32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
